// File: rtl/int_div_unit_pkg.sv
// Shared types for the iterative integer divider: token formats, opcode layout and FSM states.
`default_nettype none

package int_div_unit_pkg;

  localparam int DATA_W     = 32;
  localparam int WIDTH_COND = 3;

  typedef logic [2**WIDTH_COND-1:0] cond_t;

  typedef struct packed {
    logic cond_f;
    logic cond_b;
    logic rem;
    logic sgn;
  } opcode_ds_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  typedef struct packed {
    logic              v;
    logic              a;
    logic              c;
    logic              r;
    logic [DATA_W-1:0] d;
  } FTk_t;

  typedef struct packed {
    logic n;
    logic t;
    logic v;
    logic c;
  } BTk_t;

  // Two's-complement negate when requested; zero maps to itself.
  function automatic logic [DATA_W-1:0] cond_negate(input logic [DATA_W-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/int_div_core.sv
// Radix-2 restoring shift/subtract datapath: one quotient bit per step on unsigned magnitudes.
`default_nettype none

module int_div_core #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] r_o
);

  logic [W-1:0] q_q, q_d;
  logic [W-1:0] r_q, r_d;
  logic [W-1:0] b_q, b_d;
  logic [W:0]   trial;

  // Shifted partial remainder is below 2*|B|, so W+1 bits hold the signed difference.
  assign trial = {r_q, q_q[W-1]} - {1'b0, b_q};

  always_comb begin
    q_d = q_q;
    r_d = r_q;
    b_d = b_q;
    if (load_i) begin
      q_d = a_i;
      r_d = '0;
      b_d = b_i;
    end else if (step_i) begin
      if (!trial[W]) begin
        r_d = trial[W-1:0];
        q_d = {q_q[W-2:0], 1'b1};
      end else begin
        r_d = {r_q[W-2:0], q_q[W-1]};
        q_d = {q_q[W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
      r_q <= '0;
      b_q <= '0;
    end else begin
      q_q <= q_d;
      r_q <= r_d;
      b_q <= b_d;
    end
  end

  assign q_o = q_q;
  assign r_o = r_q;

endmodule

`default_nettype wire

// File: rtl/int_div_unit.sv
// Iterative signed/unsigned integer divider on the forward/backward token interface.
`default_nettype none

module int_div_unit
  import int_div_unit_pkg::*;
#(
  parameter int WIDTH_DATA = DATA_W,
  parameter int WIDTH_CNT  = $clog2(WIDTH_DATA) + 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       I_En,
  input  logic [3:0] I_Opcode,
  input  cond_t      I_Cond,
  input  FTk_t       I_OperandA,
  input  FTk_t       I_OperandB,
  output FTk_t       O_Result,
  input  BTk_t       I_BTk,
  output BTk_t       O_BTk
);

  div_state_t             state_q, state_d;
  logic [WIDTH_CNT-1:0]   cnt_q, cnt_d;
  opcode_ds_t             op_q, op_d;
  logic                   qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic                   c_q, c_d, r_q, r_d;
  logic [WIDTH_DATA-1:0]  res_q, res_d;

  logic                   accept, sa, sb, cond;
  logic [WIDTH_DATA-1:0]  a_mag, b_mag, core_q, core_r, quot, rem;
  logic [WIDTH_COND-1:0]  lut_addr;
  logic                   unused_w;

  assign unused_w = ^{I_OperandA.a, I_OperandB.a, I_OperandB.c, I_OperandB.r};

  assign accept = (state_q == IDLE) & I_En & I_OperandA.v & I_OperandB.v;
  assign sa     = I_Opcode[0] & I_OperandA.d[WIDTH_DATA-1];
  assign sb     = I_Opcode[0] & I_OperandB.d[WIDTH_DATA-1];
  assign a_mag  = cond_negate(I_OperandA.d, sa);
  assign b_mag  = cond_negate(I_OperandB.d, sb);

  int_div_core #(.W(WIDTH_DATA)) u_core (
    .clk_i  (clock),
    .rst_ni (reset),
    .load_i (accept),
    .step_i (state_q == CALC),
    .a_i    (a_mag),
    .b_i    (b_mag),
    .q_o    (core_q),
    .r_o    (core_r)
  );

  // On divide-by-zero the core never stepped, so core_q still holds |A|.
  assign quot = dz_q ? '1 : cond_negate(core_q, qneg_q);
  assign rem  = cond_negate(dz_q ? core_q : core_r, rneg_q);

  assign lut_addr = {res_q[WIDTH_DATA-1], dz_q, (res_q == '0)};
  assign cond     = I_Cond[lut_addr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      c_q     <= 1'b0;
      r_q     <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      c_q     <= c_d;
      r_q     <= r_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    c_d     = c_q;
    r_d     = r_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = opcode_ds_t'(I_Opcode);
          qneg_d  = sa ^ sb;
          rneg_d  = sa;
          dz_d    = (I_OperandB.d == '0);
          c_d     = I_OperandA.c;
          r_d     = I_OperandA.r;
          cnt_d   = WIDTH_CNT'(WIDTH_DATA);
          state_d = (I_OperandB.d == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == WIDTH_CNT'(1)) state_d = FIX;
      end
      FIX: begin
        res_d   = op_q.rem ? rem : quot;
        state_d = DONE;
      end
      DONE: begin
        if (!I_BTk.n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!I_En) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_comb begin
    O_Result = '0;
    if (state_q == DONE) begin
      O_Result.v = 1'b1;
      O_Result.d = res_q;
      O_Result.a = qneg_q;
      O_Result.r = r_q;
      O_Result.c = op_q.cond_f ? cond : c_q;
    end
    // Reset is sampled here so the stall request drops while reset is held.
    O_BTk.n = reset & (I_BTk.n | (state_q != IDLE));
    O_BTk.t = I_BTk.t;
    O_BTk.v = op_q.cond_b ? c_q : I_BTk.v;
    O_BTk.c = op_q.cond_b ? cond : I_BTk.c;
  end

endmodule

`default_nettype wire

// File: tb/tb_int_div_unit.sv
// Directed self-checking bench for int_div_unit.
`default_nettype none

module tb_int_div_unit;
  import int_div_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] opc;
  cond_t      cnd;
  FTk_t       opa, opb, res;
  BTk_t       bi, bo;
  int         nvec = 0;
  int         nerr = 0;

  always #5 clk = ~clk;

  int_div_unit dut (
    .clock      (clk),
    .reset      (rst_n),
    .I_En       (en),
    .I_Opcode   (opc),
    .I_Cond     (cnd),
    .I_OperandA (opa),
    .I_OperandB (opb),
    .O_Result   (res),
    .I_BTk      (bi),
    .O_BTk      (bo)
  );

  task automatic step1();
    @(posedge clk); #1;
  endtask

  // Presents one operand pair, then waits (bounded) for O_Result.v; lat counts edges after the accept edge.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       output int lat, output int busy_bad);
    opc = op;
    opa = '{v:1'b1, a:1'b0, c:1'b0, r:1'b1, d:a};
    opb = '{v:1'b1, a:1'b0, c:1'b0, r:1'b0, d:b};
    step1();
    opa.v = 1'b0;
    opb.v = 1'b0;
    lat = 0;
    busy_bad = 0;
    while (res.v !== 1'b1 && lat < 100) begin
      if (bo.n !== 1'b1) busy_bad++;
      step1();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bi = '{n:1'b1, t:1'b1, v:1'b1, c:1'b0};
    #12;
    nvec++; if (res !== '0) begin nerr++; $display("FAIL reset_result: got %h want 0", res); end
    nvec++; if (bo.n !== 1'b0 || bo.t !== 1'b1 || bo.v !== 1'b1 || bo.c !== 1'b0) begin nerr++; $display("FAIL reset_btk: got %b want 0110", bo); end
    step1();
    rst_n = 1'b1;
    bi = '0;
    step1();
    nvec++; if (res.v !== 1'b0 || bo.n !== 1'b0) begin nerr++; $display("FAIL idle_after_reset: got v=%b n=%b want 0 0", res.v, bo.n); end
  endtask

  task automatic test_unsigned();
    int lat, bb;
    do_op(32'd100, 32'd7, 4'b0000, lat, bb);
    nvec++; if (res.d !== 32'd14) begin nerr++; $display("FAIL u_quot: got %h want %h", res.d, 32'd14); end
    nvec++; if (lat !== 33) begin nerr++; $display("FAIL u_latency: got %0d want 33 edges after accept", lat); end
    nvec++; if (bb !== 0) begin nerr++; $display("FAIL u_busy: got %0d cycles with n=0 want 0", bb); end
    nvec++; if (res.a !== 1'b0 || res.r !== 1'b1 || res.c !== 1'b0) begin nerr++; $display("FAIL u_fields: got a=%b r=%b c=%b want 0 1 0", res.a, res.r, res.c); end
    step1();
    nvec++; if (bo.n !== 1'b0 || res.v !== 1'b0) begin nerr++; $display("FAIL u_back_idle: got n=%b v=%b want 0 0", bo.n, res.v); end
    do_op(32'd100, 32'd7, 4'b0010, lat, bb);
    nvec++; if (res.d !== 32'd2) begin nerr++; $display("FAIL u_rem: got %h want %h", res.d, 32'd2); end
    step1();
  endtask

  task automatic test_signed();
    int lat, bb;
    cnd = 8'h10;
    do_op(32'hFFFFFF9C, 32'd7, 4'b1001, lat, bb);
    nvec++; if (res.d !== 32'hFFFFFFF2) begin nerr++; $display("FAIL s_quot: got %h want FFFFFFF2", res.d); end
    nvec++; if (res.a !== 1'b1 || res.c !== 1'b1) begin nerr++; $display("FAIL s_cond: got a=%b c=%b want 1 1", res.a, res.c); end
    step1();
    do_op(32'hFFFFFF9C, 32'd7, 4'b0011, lat, bb);
    nvec++; if (res.d !== 32'hFFFFFFFE) begin nerr++; $display("FAIL s_rem: got %h want FFFFFFFE", res.d); end
    nvec++; if (res.c !== 1'b0) begin nerr++; $display("FAIL s_captured_c: got %b want 0", res.c); end
    step1();
    do_op(32'd100, 32'hFFFFFFF9, 4'b0001, lat, bb);
    nvec++; if (res.d !== 32'hFFFFFFF2) begin nerr++; $display("FAIL s_quot_negb: got %h want FFFFFFF2", res.d); end
    step1();
    do_op(32'd100, 32'hFFFFFFF9, 4'b0011, lat, bb);
    nvec++; if (res.d !== 32'd2) begin nerr++; $display("FAIL s_rem_negb: got %h want 2", res.d); end
    step1();
  endtask

  task automatic test_div_zero();
    int lat, bb;
    cnd = 8'h04;
    do_op(32'd55, 32'd0, 4'b0000, lat, bb);
    nvec++; if (res.d !== 32'hFFFFFFFF) begin nerr++; $display("FAIL dz_quot: got %h want FFFFFFFF", res.d); end
    nvec++; if (lat !== 1) begin nerr++; $display("FAIL dz_latency: got %0d want 1 edge after accept", lat); end
    step1();
    do_op(32'd55, 32'd0, 4'b1010, lat, bb);
    nvec++; if (res.d !== 32'd55) begin nerr++; $display("FAIL dz_rem: got %h want %h", res.d, 32'd55); end
    nvec++; if (res.c !== 1'b1) begin nerr++; $display("FAIL dz_lut: got c=%b want 1", res.c); end
    step1();
    do_op(32'hFFFFFFFB, 32'd0, 4'b0011, lat, bb);
    nvec++; if (res.d !== 32'hFFFFFFFB) begin nerr++; $display("FAIL dz_rem_signed: got %h want FFFFFFFB", res.d); end
    step1();
  endtask

  task automatic test_overflow();
    int lat, bb;
    cnd = 8'h02;
    do_op(32'h80000000, 32'hFFFFFFFF, 4'b0001, lat, bb);
    nvec++; if (res.d !== 32'h80000000 || lat !== 33) begin nerr++; $display("FAIL ovf_quot: got %h lat %0d want 80000000 lat 33", res.d, lat); end
    step1();
    do_op(32'h80000000, 32'hFFFFFFFF, 4'b1011, lat, bb);
    nvec++; if (res.d !== 32'd0 || res.c !== 1'b1) begin nerr++; $display("FAIL ovf_rem: got %h c=%b want 0 c=1", res.d, res.c); end
    step1();
  endtask

  task automatic test_back_to_back();
    int lat, bb;
    bi.n = 1'b1;
    do_op(32'd1000, 32'd10, 4'b0000, lat, bb);
    nvec++; if (res.d !== 32'd100 || bb !== 0) begin nerr++; $display("FAIL bp_result: got %h busy_bad %0d want 100 0", res.d, bb); end
    for (int i = 0; i < 5; i++) begin
      step1();
      nvec++; if (res.v !== 1'b1 || res.d !== 32'd100 || bo.n !== 1'b1) begin nerr++; $display("FAIL bp_hold%0d: got v=%b d=%h n=%b want 1 100 1", i, res.v, res.d, bo.n); end
    end
    bi.n = 1'b0;
    opc = 4'b0000;
    opa = '{v:1'b1, a:1'b0, c:1'b0, r:1'b1, d:32'd77};
    opb = '{v:1'b1, a:1'b0, c:1'b0, r:1'b0, d:32'd5};
    step1();
    nvec++; if (res.v !== 1'b0 || bo.n !== 1'b0) begin nerr++; $display("FAIL b2b_idle: got v=%b n=%b want 0 0", res.v, bo.n); end
    step1();
    opa.v = 1'b0;
    opb.v = 1'b0;
    nvec++; if (bo.n !== 1'b1) begin nerr++; $display("FAIL b2b_accept: got n=%b want 1", bo.n); end
    lat = 0;
    while (res.v !== 1'b1 && lat < 100) begin step1(); lat++; end
    nvec++; if (res.d !== 32'd15 || lat !== 33) begin nerr++; $display("FAIL b2b_result: got %h lat %0d want f lat 33", res.d, lat); end
    step1();
  endtask

  task automatic test_abort_en();
    int lat, bb, pulses;
    opc = 4'b0000;
    opa = '{v:1'b1, a:1'b0, c:1'b0, r:1'b1, d:32'd100};
    opb = '{v:1'b1, a:1'b0, c:1'b0, r:1'b0, d:32'd7};
    step1();
    opa.v = 1'b0;
    opb.v = 1'b0;
    repeat (10) step1();
    en = 1'b0;
    step1();
    nvec++; if (bo.n !== 1'b0) begin nerr++; $display("FAIL abort_idle: got n=%b want 0", bo.n); end
    en = 1'b1;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      if (res.v === 1'b1) pulses++;
      step1();
    end
    nvec++; if (pulses !== 0) begin nerr++; $display("FAIL abort_no_result: got %0d valid cycles want 0", pulses); end
    do_op(32'd100, 32'd7, 4'b0000, lat, bb);
    nvec++; if (res.d !== 32'd14) begin nerr++; $display("FAIL abort_recover: got %h want e", res.d); end
    step1();
  endtask

  task automatic test_async_reset();
    int lat, bb;
    opc = 4'b0000;
    opa = '{v:1'b1, a:1'b0, c:1'b0, r:1'b1, d:32'd100};
    opb = '{v:1'b1, a:1'b0, c:1'b0, r:1'b0, d:32'd7};
    step1();
    opa.v = 1'b0;
    opb.v = 1'b0;
    repeat (5) step1();
    nvec++; if (bo.n !== 1'b1) begin nerr++; $display("FAIL areset_busy: got n=%b want 1", bo.n); end
    rst_n = 1'b0;
    #1;
    nvec++; if (res !== '0 || bo.n !== 1'b0) begin nerr++; $display("FAIL areset_calc: got res=%h n=%b want 0 0", res, bo.n); end
    step1();
    rst_n = 1'b1;
    bi.n = 1'b1;
    do_op(32'd100, 32'd7, 4'b0000, lat, bb);
    #2;
    rst_n = 1'b0;
    #1;
    nvec++; if (res !== '0 || bo.n !== 1'b0) begin nerr++; $display("FAIL areset_done: got res=%h n=%b want 0 0", res, bo.n); end
    step1();
    rst_n = 1'b1;
    bi.n = 1'b0;
    step1();
  endtask

  initial begin
    en  = 1'b1;
    opc = 4'b0000;
    cnd = '0;
    opa = '0;
    opb = '0;
    bi  = '0;
    rst_n = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_abort_en();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/int_div_unit.md
Name: int_div_unit

Overview:
- Iterative integer divider: inverse-direction counterpart of the pipelined integer multiplier in the ALU.
- Consumes the same forward token stream (FTk_t operands) and backward token stream (BTk_t).
- Produces quotient or remainder using radix-2 restoring division, one bit per cycle.
- Holds upstream with O_BTk.n while busy, because it is multi-cycle rather than fully pipelined.

Parameters:
- WIDTH_DATA, 32: operand/result width; must be even and at least 8.
- WIDTH_CNT, $clog2(WIDTH_DATA)+1: iteration counter width.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- I_En  in  1  unit enable; deassertion aborts any operation.
- I_Opcode  in  4  bit0 signed, bit1 select remainder (0 = quotient), bit2 OutCondB, bit3 OutCondF.
- I_Cond  in  2^WIDTH_COND  condition LUT.
- I_OperandA  in  FTk_t  dividend token.
- I_OperandB  in  FTk_t  divisor token.
- O_Result  out  FTk_t  result token.
- I_BTk  in  BTk_t  backward token from consumer.
- O_BTk  out  BTk_t  backward token to producer.

Behaviour:
- Reset (async, reset==0): state IDLE, counter 0. O_Result all fields 0. O_BTk passes I_BTk with n forced 0.
- State IDLE:
  - Accept when I_En & I_OperandA.v & I_OperandB.v.
  - Capture |A|, |B|: two's-complement magnitude only when bit0=1 and the operand MSB=1.
  - Capture result signs: QNeg = SA^SB, RNeg = SA.
  - Capture opcode, and the a/c/r fields of OperandA.
  - Go to CALC with counter = WIDTH_DATA.
- State CALC, each cycle:
  - Shift {R,Q} left 1.
  - Trial = R - |B| at WIDTH_DATA+1 bits. If non-negative: R = Trial, Q[0] = 1.
  - Decrement counter; on reaching 0 go to FIX.
- State FIX (1 cycle): apply sign correction, div-by-zero and overflow rules; register the result; go to DONE.
- State DONE:
  - O_Result.v = 1 with the registered result.
  - Hold while I_BTk.n = 1.
  - On I_BTk.n = 0, return to IDLE next cycle. The next operation may be accepted in that same IDLE cycle.
- Latency: accept edge to O_Result.v = WIDTH_DATA+2 cycles (34 at default). Throughput: 1 result per WIDTH_DATA+3 cycles.
- O_BTk.n = I_BTk.n | (state != IDLE). Upstream must hold operands while n = 1.
- Divide by zero (B == 0):
  - Quotient = all ones; remainder = dividend unmodified.
  - DZ flag = 1.
  - CALC is skipped; IDLE goes straight to FIX. Latency is 2.
- Signed overflow (A = 0x80000000, B = 0xFFFFFFFF, signed): quotient 0x80000000, remainder 0. Normal CALC runs.
- Result selection:
  - Result = bit1 ? Rsigned : Qsigned.
  - Negation is applied only when the corresponding Neg flag is set and the value is nonzero.
- Condition code: LUTAddr = {Result[MSB], DZ, Result == 0}; Cond = I_Cond[LUTAddr].
- O_Result fields:
  - c = OutCondF ? Cond : captured c.
  - a = QNeg.
  - r = captured r.
  - i passes through under EXTEND.
- O_BTk: n as above; t = I_BTk.t. v = OutCondB ? captured c : I_BTk.v. c = OutCondB ? Cond : I_BTk.c.
- I_En = 0 in any state: next cycle is IDLE and O_Result.v = 0. The aborted result is never emitted.
- Operand v seen while not in IDLE: ignored, no capture.
- Reset asserted mid-operation: immediate abort, all outputs at reset values.

Decomposition:
- pkg_alu:
  - opcode_ds_t (4-bit divider opcode).
  - div_state_t enum {IDLE, CALC, FIX, DONE}.
  - Existing WIDTH_COND and cond_t are reused.
- pkg_en: FTk_t and BTk_t, unchanged.
- Sub-module int_div_core holds the shift/subtract datapath:
  - Inputs: load, step, |A|, |B|.
  - Outputs: Q, R.
  - int_div_unit owns the FSM, sign handling and the token interface.

Test Plan:
- Unsigned 100 / 7 (bit0=0, bit1=0) -> O_Result.d = 14 at accept+34 cycles. With bit1=1 -> 2. O_BTk.n = 1 for cycles 1..34.
- Signed -100 / 7 (0xFFFFFF9C, 7):
  - Quotient 0xFFFFFFF2 (-14), O_Result.a = 1.
  - Remainder 0xFFFFFFFE (-2).
  - Cond LUT with only entry 3'b100 set -> O_Result.c = 1 when OutCondF = 1.
- Divide by zero 55 / 0 -> quotient 0xFFFFFFFF, remainder 55, result valid at accept+2. LUTAddr DZ bit = 1.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; no X, no hang.
- Back-pressure and abort:
  - Hold I_BTk.n = 1 for 5 cycles in DONE -> O_Result stable and v = 1 throughout; release -> IDLE; back-to-back operand accepted.
  - Drop I_En mid-CALC -> no O_Result.v pulse.
  - Pulse reset low mid-CALC -> all outputs 0 asynchronously, before the next clock edge.
